armleosoc_mtime_timebase: RTL and testbench

Programmable timebase controller that generates the `mtime_increment` strobe consumed by `armleosoc_axi_clint`. A fractional phase accumulator derives an exact RISC-V timer rate from an arbitrary `clk`, with software control of enable, rate, and optional freeze while any hart is in debug mode. It sits behind an `armleosoc_axi2simple_converter` instance on the SoC peripheral bus and drives the CLINT directly.

---
 rtl/armleosoc_mtime_timebase_pkg.sv | 35 +++
 rtl/armleosoc_mtime_timebase_if.sv | 24 ++
 rtl/armleosoc_phase_accumulator.sv | 41 ++++
 rtl/armleosoc_mtime_timebase.sv | 128 ++++++++++++
 tb/tb_armleosoc_mtime_timebase.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/armleosoc_mtime_timebase_pkg.sv
// Shared constants and types for the mtime timebase: register offsets, CTRL bit indices, state encoding.
// The optional debug-halt feature is selected with ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN.
package armleosoc_mtime_timebase_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [ADDR_W-1:0] REG_CTRL        = 4'h0;
  localparam logic [ADDR_W-1:0] REG_INC         = 4'h4;
  localparam logic [ADDR_W-1:0] REG_PULSE_COUNT = 4'h8;
  localparam logic [ADDR_W-1:0] REG_STATUS      = 4'hC;

  localparam int unsigned CTRL_ENABLE_BIT        = 0;
  localparam int unsigned CTRL_HALT_ON_DEBUG_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Merge the enabled bytes of new_v into old_v.
  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/armleosoc_mtime_timebase_if.sv
// Simple-bus register interface between the axi2simple converter (master) and the timebase (slave).
interface armleosoc_mtime_timebase_if;
  import armleosoc_mtime_timebase_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   write_byteenable;
  logic [DATA_W-1:0] read_data;
  logic              address_error;
  logic              write_error;

  modport master (
    output address, write, read, write_data, write_byteenable,
    input  read_data, address_error, write_error
  );

  modport slave (
    input  address, write, read, write_data, write_byteenable,
    output read_data, address_error, write_error
  );

endinterface

// File: rtl/armleosoc_phase_accumulator.sv
// 32-bit fractional phase accumulator; the carry out of each step is registered and is the pulse output.
module armleosoc_phase_accumulator
  import armleosoc_mtime_timebase_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              hold,
  input  logic              step,
  input  logic [DATA_W-1:0] inc,
  output logic              carry
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DATA_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc};
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (step && !hold) begin
      {carry_d, acc_d} = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

endmodule

// File: rtl/armleosoc_mtime_timebase.sv
// Programmable mtime_increment generator for the CLINT: register block, run/halt FSM, phase accumulator.
// Define ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN to implement CTRL.halt_on_debug and the HALTED state.
module armleosoc_mtime_timebase
  import armleosoc_mtime_timebase_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_INC    = 32'h0000_0000,
  parameter logic              RESET_ENABLE = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  armleosoc_mtime_timebase_if.slave   bus,
  input  logic                        debug_halt,
  output logic                        mtime_increment
);

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              halt_on_debug_q;
  logic [DATA_W-1:0] inc_q, inc_d;
  logic [DATA_W-1:0] pulse_count_q, pulse_count_d;
  logic              halt_req;
  logic              acc_clear, acc_hold, acc_step;

`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
  logic halt_on_debug_d;
  assign halt_req = halt_on_debug_q & debug_halt;
`else
  logic unused_debug_halt;
  assign unused_debug_halt = debug_halt;
  assign halt_on_debug_q   = 1'b0;
  assign halt_req          = 1'b0;
`endif

  // Next state and accumulator controls from the current register values.
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_hold  = 1'b0;
    acc_step  = 1'b0;
    if (!enable_q) begin
      state_d   = ST_IDLE;
      acc_clear = 1'b1;
    end else if (halt_req) begin
      state_d  = ST_HALTED;
      acc_hold = 1'b1;
    end else begin
      state_d  = ST_RUN;
      acc_step = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Register writes; a software PULSE_COUNT write overrides the same-cycle increment.
  always_comb begin
    enable_d      = enable_q;
`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
    halt_on_debug_d = halt_on_debug_q;
`endif
    inc_d         = inc_q;
    pulse_count_d = pulse_count_q + DATA_W'(mtime_increment);
    if (bus.write) begin
      case (bus.address)
        REG_CTRL: begin
          if (bus.write_byteenable[0]) begin
            enable_d = bus.write_data[CTRL_ENABLE_BIT];
`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
            halt_on_debug_d = bus.write_data[CTRL_HALT_ON_DEBUG_BIT];
`endif
          end
        end
        REG_INC:         inc_d = apply_be(inc_q, bus.write_data, bus.write_byteenable);
        REG_PULSE_COUNT: pulse_count_d = apply_be(pulse_count_q, bus.write_data, bus.write_byteenable);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_q      <= RESET_ENABLE;
      inc_q         <= RESET_INC;
      pulse_count_q <= '0;
    end else begin
      enable_q      <= enable_d;
      inc_q         <= inc_d;
      pulse_count_q <= pulse_count_d;
    end
  end

`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) halt_on_debug_q <= 1'b0;
    else        halt_on_debug_q <= halt_on_debug_d;
  end
`endif

  // Combinational read path and error flags for the converter.
  always_comb begin
    bus.read_data     = '0;
    bus.address_error = (bus.read | bus.write) & (bus.address[1:0] != 2'b00);
    bus.write_error   = bus.write & (bus.address == REG_STATUS);
    case (bus.address)
      REG_CTRL: begin
        bus.read_data[CTRL_ENABLE_BIT]        = enable_q;
        bus.read_data[CTRL_HALT_ON_DEBUG_BIT] = halt_on_debug_q;
      end
      REG_INC:         bus.read_data = inc_q;
      REG_PULSE_COUNT: bus.read_data = pulse_count_q;
      REG_STATUS:      bus.read_data = {(DATA_W-2)'(0), state_q};
      default: ;
    endcase
  end

  armleosoc_phase_accumulator u_phase_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .hold  (acc_hold),
    .step  (acc_step),
    .inc   (inc_q),
    .carry (mtime_increment)
  );

endmodule

// File: tb/tb_armleosoc_mtime_timebase.sv
// Directed bench for armleosoc_mtime_timebase; every task starts and ends just after a falling edge.
module tb_armleosoc_mtime_timebase;
  import armleosoc_mtime_timebase_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debug_halt = 1'b0;
  logic mtime_increment;
  int   errors = 0;
  int   checks = 0;

  armleosoc_mtime_timebase_if bus ();

  armleosoc_mtime_timebase #(
    .RESET_INC   (32'h4000_0000),
    .RESET_ENABLE(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .debug_halt     (debug_halt),
    .mtime_increment(mtime_increment)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address = a; bus.write_data = d; bus.write_byteenable = be; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    #1;
    d = bus.read_data;
    bus.read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [11:0] pat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mtime_increment !== 1'b0) begin errors++; $display("FAIL reset_pin: got %b want 0", mtime_increment); end
    bus_read(REG_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
    bus_read(REG_CTRL, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h want 1", d); end
    bus_read(REG_INC, d);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL reset_inc: got %h want 40000000", d); end
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", d); end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = mtime_increment;
    end
    checks++; if (pat !== 12'b1000_1000_1000) begin errors++; $display("FAIL reset_quarter_rate: got %b want 100010001000", pat); end
  endtask

  task automatic test_half_rate();
    logic [31:0] d;
    int hits, consec;
    logic prev;
    hits = 0; consec = 0; prev = 1'b0;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'h8000_0000, 4'hF);
    bus_write(REG_PULSE_COUNT, 32'h0, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 1001; i++) begin
      @(negedge clk);
      if (mtime_increment && prev) consec++;
      if (mtime_increment) hits++;
      prev = mtime_increment;
    end
    checks++; if (hits != 500) begin errors++; $display("FAIL half_rate_pulses: got %0d want 500", hits); end
    checks++; if (consec != 0) begin errors++; $display("FAIL half_rate_consecutive: got %0d want 0", consec); end
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'd500) begin errors++; $display("FAIL half_rate_count: got %0d want 500", d); end
  endtask

  task automatic test_inc_boundaries();
    int hits;
    hits = 0;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'hFFFF_FFFF, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (mtime_increment) hits++;
    end
    checks++; if (hits != 255) begin errors++; $display("FAIL inc_max_pulses: got %0d want 255", hits); end
    bus_write(REG_INC, 32'h0, 4'hF);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mtime_increment) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL inc_zero_pulses: got %0d want 0", hits); end
  endtask

  task automatic test_debug_halt();
    logic [31:0] d;
    int pre_hits, hits, first_idx;
    int exp_hits, exp_idx;
    logic [31:0] exp_status;
`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
    exp_status = 32'd2; exp_hits = 0; exp_idx = 2;
`else
    exp_status = 32'd1; exp_hits = 2; exp_idx = 0;
`endif
    pre_hits = 0; hits = 0; first_idx = -1;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'h4000_0000, 4'hF);
    bus_write(REG_CTRL, 32'h3, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mtime_increment) pre_hits++;
    end
    checks++; if (pre_hits != 1) begin errors++; $display("FAIL halt_pre_pulses: got %0d want 1", pre_hits); end
    debug_halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mtime_increment) hits++;
      if (i == 0) begin
        bus_read(REG_STATUS, d);
        checks++; if (d !== exp_status) begin errors++; $display("FAIL halt_status: got %0d want %0d", d, exp_status); end
      end
    end
    checks++; if (hits != exp_hits) begin errors++; $display("FAIL halt_pulses: got %0d want %0d", hits, exp_hits); end
    debug_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mtime_increment && first_idx < 0) first_idx = i;
    end
    checks++; if (first_idx != exp_idx) begin errors++; $display("FAIL halt_resume_phase: got %0d want %0d", first_idx, exp_idx); end
  endtask

  task automatic test_disable_and_errors();
    logic [31:0] d;
    logic [3:0] pat;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_read(REG_STATUS, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL disable_status_same_edge: got %0d want 1", d); end
    @(negedge clk);
    bus_read(REG_STATUS, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL disable_status_idle: got %0d want 0", d); end
    checks++; if (mtime_increment !== 1'b0) begin errors++; $display("FAIL disable_pin: got %b want 0", mtime_increment); end
    bus.address = REG_STATUS; bus.write_data = 32'hFFFF_FFFF; bus.write_byteenable = 4'hF; bus.write = 1'b1;
    #1;
    checks++; if (bus.write_error !== 1'b1) begin errors++; $display("FAIL status_write_error: got %b want 1", bus.write_error); end
    checks++; if (bus.address_error !== 1'b0) begin errors++; $display("FAIL status_address_error: got %b want 0", bus.address_error); end
    @(negedge clk);
    bus.write = 1'b0;
    bus_read(REG_STATUS, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL status_after_write: got %0d want 0", d); end
    bus.address = 4'h2; bus.read = 1'b1;
    #1;
    checks++; if (bus.address_error !== 1'b1) begin errors++; $display("FAIL misaligned_address_error: got %b want 1", bus.address_error); end
    bus.read = 1'b0;
    // Re-enable with INC already 0x4000_0000: a cleared phase pulses on the 4th step.
    bus_write(REG_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = mtime_increment;
    end
    checks++; if (pat !== 4'b1000) begin errors++; $display("FAIL reenable_phase: got %b want 1000", pat); end
  endtask

  task automatic test_pulse_count();
    logic [31:0] d;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'hFFFF_FFFF, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    checks++; if (mtime_increment !== 1'b1) begin errors++; $display("FAIL count_pin_active: got %b want 1", mtime_increment); end
    bus_write(REG_PULSE_COUNT, 32'h0000_0010, 4'hF);
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL count_write_wins: got %h want 00000010", d); end
    bus_write(REG_PULSE_COUNT, 32'hFFFF_FFFF, 4'hF);
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_preload: got %h want ffffffff", d); end
    @(negedge clk);
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h want 00000000", d); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d, exp_ctrl;
`ifdef ARMLEOSOC_MTIME_TIMEBASE_DEBUG_HALT_EN
    exp_ctrl = 32'h3;
`else
    exp_ctrl = 32'h1;
`endif
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'hFFFF_FFFF, 4'hF);
    bus_write(REG_INC, 32'h0000_0000, 4'b0101);
    bus_read(REG_INC, d);
    checks++; if (d !== 32'hFF00_FF00) begin errors++; $display("FAIL inc_byteenable: got %h want ff00ff00", d); end
    bus_write(REG_CTRL, 32'hFFFF_FFFF, 4'hF);
    bus_read(REG_CTRL, d);
    checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL ctrl_bits: got %h want %h", d, exp_ctrl); end
    bus_write(REG_CTRL, 32'h0, 4'h0);
    bus_read(REG_CTRL, d);
    checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL ctrl_no_be: got %h want %h", d, exp_ctrl); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    bus_write(REG_CTRL, 32'h0, 4'hF);
    bus_write(REG_INC, 32'hFFFF_FFFF, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (mtime_increment !== 1'b0) begin errors++; $display("FAIL midreset_pin: got %b want 0", mtime_increment); end
    bus_read(REG_PULSE_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_count: got %h want 0", d); end
    bus_read(REG_INC, d);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL midreset_inc: got %h want 40000000", d); end
    bus_read(REG_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 0", d); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.read = 1'b0;
    bus.write_data = '0; bus.write_byteenable = '0;
    test_reset();
    test_half_rate();
    test_inc_boundaries();
    test_debug_halt();
    test_disable_and_errors();
    test_pulse_count();
    test_byteenable();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
